// File: rtl/stopwatch_timer.sv
// Stopwatch timekeeping core: two debounced push-buttons drive an IDLE/RUNNING/PAUSED
// controller that advances binary minutes:seconds from a clock-cycle prescaler.
module stopwatch_timer #(
    parameter int TICKS_PER_SECOND = 50000000,
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int MAX_MINUTES      = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic [6:0] minutes,
    output logic [6:0] seconds,
    output logic       running,
    output logic       wrapped
);

    localparam int PW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SECOND - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0]    MIN_LAST   = 7'(MAX_MINUTES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2
    } state_t;

    // Index 0 = start/stop, index 1 = clear.
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_clear, btn_start_stop};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          sync3_reg;
            logic          level_reg;
            logic          level_d_reg;
            logic [CW-1:0] cnt_reg;

            // sync3 holds last cycle's synchronised level, so a change restarts the count.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    sync3_reg   <= 1'b0;
                    level_reg   <= 1'b0;
                    level_d_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    sync1_reg   <= btn_raw[gi];
                    sync2_reg   <= sync1_reg;
                    sync3_reg   <= sync2_reg;
                    level_d_reg <= level_reg;
                    if ((sync2_reg != level_reg) && (sync2_reg == sync3_reg)) begin
                        if (cnt_reg == DEB_LAST) begin
                            level_reg <= sync2_reg;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign press[gi] = level_reg & ~level_d_reg;
        end
    endgenerate

    state_t        state_reg;
    logic [PW-1:0] presc_reg;
    logic [6:0]    min_reg;
    logic [6:0]    sec_reg;
    logic          running_reg;
    logic          wrapped_reg;

    // Transition edges themselves do not count; the prescaler only moves while staying in RUNNING.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            presc_reg   <= '0;
            min_reg     <= '0;
            sec_reg     <= '0;
            running_reg <= 1'b0;
            wrapped_reg <= 1'b0;
        end else begin
            wrapped_reg <= 1'b0;
            if (press[1]) begin
                state_reg   <= S_IDLE;
                running_reg <= 1'b0;
                presc_reg   <= '0;
                min_reg     <= '0;
                sec_reg     <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (press[0]) begin
                            state_reg   <= S_RUNNING;
                            running_reg <= 1'b1;
                            presc_reg   <= '0;
                        end
                    end
                    S_RUNNING: begin
                        if (press[0]) begin
                            state_reg   <= S_PAUSED;
                            running_reg <= 1'b0;
                        end else if (presc_reg == PRESC_LAST) begin
                            presc_reg <= '0;
                            if (sec_reg < 7'd59) begin
                                sec_reg <= sec_reg + 7'd1;
                            end else begin
                                sec_reg <= '0;
                                if (min_reg < MIN_LAST) begin
                                    min_reg <= min_reg + 7'd1;
                                end else begin
                                    min_reg     <= '0;
                                    wrapped_reg <= 1'b1;
                                end
                            end
                        end else begin
                            presc_reg <= presc_reg + 1'b1;
                        end
                    end
                    S_PAUSED: begin
                        if (press[0]) begin
                            state_reg   <= S_RUNNING;
                            running_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg   <= S_IDLE;
                        running_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign minutes = min_reg;
    assign seconds = sec_reg;
    assign running = running_reg;
    assign wrapped = wrapped_reg;

endmodule

// File: doc/stopwatch_timer.md
Name: stopwatch_timer

Overview:
Timekeeping core of the stopwatch. It sits directly upstream of the seven-segment display driver. It takes the two raw push-buttons (start/stop and clear), synchronises and debounces them, and runs a small IDLE/RUNNING/PAUSED state machine. A clock-cycle prescaler drives binary minutes (0-99) and seconds (0-59) counters, which feed the display driver's minutes/seconds inputs directly.

Parameters:
TICKS_PER_SECOND, 50000000, clock cycles per one-second increment (50 MHz board clock); minimum 2; benches use 10
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a button level is accepted (10 ms); minimum 1; benches use 4
MAX_MINUTES, 99, highest minutes value before wrap; must be <= 99 (two display digits, 7-bit field)

Ports:
clock  input  1  board clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
btn_start_stop  input  1  raw button, active-high, asynchronous to clock, bouncy
btn_clear  input  1  raw button, active-high, asynchronous to clock, bouncy
minutes  output  7  binary minutes, 0..MAX_MINUTES
seconds  output  7  binary seconds, 0..59
running  output  1  high while state is RUNNING
wrapped  output  1  one-cycle pulse on MAX_MINUTES:59 -> 00:00 rollover

Behaviour:
- Reset (async assert, sync release): state=IDLE, minutes=0, seconds=0, running=0, wrapped=0, prescaler=0, synchroniser flops=0, debounced levels=0, debounce counters=0, edge registers=0.
- Button path, identical per button:
  - 2-flop synchroniser.
  - Debounce counter resets to 0 whenever the synchronised level equals the current debounced level or differs from its value in the previous cycle.
  - Debounce counter increments while the synchronised level differs from the debounced level and is stable; when the count reaches DEBOUNCE_CYCLES-1, the debounced level flips on the next edge.
  - Rising edge of the debounced level produces a one-cycle press pulse. Falling edges produce nothing.
  - Latency: a clean raw 0->1 step sampled on edge N gives a press pulse usable by the FSM on edge N+DEBOUNCE_CYCLES+3.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse.
- FSM, evaluated on press pulses:
  - IDLE + start_stop -> RUNNING, prescaler starts from 0.
  - RUNNING + start_stop -> PAUSED.
  - PAUSED + start_stop -> RUNNING, prescaler resumes from its held value so the partial second is preserved.
  - Any state + clear -> IDLE: minutes=0, seconds=0, prescaler=0.
  - clear and start_stop pulses in the same cycle -> clear wins; start_stop is discarded.
  - Holding a button gives exactly one pulse; release, then press again, gives another.
- Prescaler:
  - Width clog2(TICKS_PER_SECOND). Counts only in RUNNING; holds in PAUSED; 0 in IDLE.
  - On the edge where prescaler == TICKS_PER_SECOND-1: prescaler -> 0 and the time advances by one second on that same edge.
  - Result: the first seconds increment occurs TICKS_PER_SECOND cycles after entering RUNNING from IDLE.
- Time advance:
  - seconds < 59: seconds+1.
  - seconds == 59, minutes < MAX_MINUTES: seconds=0, minutes+1.
  - seconds == 59, minutes == MAX_MINUTES: 00:00, wrapped=1 for exactly that one cycle; FSM stays RUNNING.
- If clear and the advance edge coincide, clear wins and the result is 00:00 with wrapped=0.
- Outputs: all outputs are registered with no combinational path from the inputs. running = (state==RUNNING).
- Invariants, required of the design and asserted by the bench: seconds <= 59 and minutes <= MAX_MINUTES at all times; minutes/seconds change only in RUNNING or on clear.
- Reset mid-count: outputs zero immediately and asynchronously; after release, the block needs a fresh press to run.

Test Plan:
(All with TICKS_PER_SECOND=10, DEBOUNCE_CYCLES=4, MAX_MINUTES=99.)
1. Release reset, clean start_stop press held 20 cycles -> exactly one pulse, running=1; seconds=1 after 10 more cycles, seconds=5 after 50.
2. start_stop bounce of pulses 1,2,3 cycles wide separated by 1-cycle lows, then stable high 10 cycles -> exactly one press, so only one state change.
3. Run to 00:03 plus 4 prescaler cycles, press start_stop -> running=0, count frozen 100 cycles; press again -> running=1, 00:04 appears 6 cycles after the resume pulse.
4. Run 600 ticks from 00:00 -> seconds 58, 59, then minutes=1, seconds=0 on the same edge; seconds never reads 60.
5. Run to 99:59 (or force via long run) -> next tick gives 00:00, wrapped high exactly one cycle, running stays 1.
6. Assert clear and start_stop with identical timing while RUNNING at 00:07 -> IDLE, 00:00, running=0. Then assert reset mid-count at 00:02 -> all outputs 0 asynchronously, no count after release until a new press.
